// File: rtl/phase_sequencer_if.sv
// Handshake bundle between the processor wrapper (master) and the phase sequencer (slave).
interface phase_sequencer_if #(
  parameter int PHASES    = 3,
  parameter int IRQ_COUNT = 24
);
  localparam int IRQ_ID_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

  logic                 run;
  logic                 mem_ready;
  logic [IRQ_COUNT-1:0] irq;
  logic [IRQ_COUNT-1:0] irq_mask;
  logic                 ie_set;
  logic [PHASES-1:0]    phase;
  logic                 last_phase;
  logic                 stall;
  logic [IRQ_COUNT-1:0] irq_pending;
  logic                 irq_valid;
  logic                 irq_take;
  logic [IRQ_ID_W-1:0]  taken_id;
  logic                 ie;

  modport master (
    output run, mem_ready, irq, irq_mask, ie_set,
    input  phase, last_phase, stall, irq_pending, irq_valid, irq_take, taken_id, ie
  );

  modport slave (
    input  run, mem_ready, irq, irq_mask, ie_set,
    output phase, last_phase, stall, irq_pending, irq_valid, irq_take, taken_id, ie
  );
endinterface

// File: rtl/phase_sequencer.sv
// One-hot instruction-phase sequencer with wait-state stalling, run/halt control and
// an edge-latched, prioritised, maskable interrupt front end taken at instruction boundaries.
module phase_sequencer #(
  parameter int PHASES    = 3,
  parameter int IRQ_COUNT = 24
) (
  input  logic              clk,
  input  logic              rst,
  phase_sequencer_if.slave  bus
);
  localparam int IRQ_ID_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
  localparam logic [PHASES-1:0] PHASE_P0 = {{(PHASES-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e               state_q, state_d;
  logic [PHASES-1:0]    phase_q, phase_d;
  logic [IRQ_COUNT-1:0] pending_q, pending_d;
  logic [IRQ_COUNT-1:0] irq_prev_q, irq_prev_d;
  logic                 ie_q, ie_d;
  logic                 irq_take_q, irq_take_d;
  logic [IRQ_ID_W-1:0]  taken_id_q, taken_id_d;

  logic [IRQ_COUNT-1:0] masked;
  logic [IRQ_COUNT-1:0] clr_vec;
  logic [IRQ_ID_W-1:0]  sel_id;
  logic                 sel_found;
  logic                 last_phase;
  logic                 irq_valid;
  logic                 take;

  assign last_phase = phase_q[PHASES-1] & bus.mem_ready;
  assign masked     = pending_q & bus.irq_mask;
  assign irq_valid  = ie_q & (|masked);
  assign take       = last_phase & irq_valid;

  // Lowest-index enabled request wins.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
      if (masked[i] && !sel_found) begin
        sel_id    = IRQ_ID_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_BUSY;
          phase_d = PHASE_P0;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ready) begin
          if (phase_q[PHASES-1]) begin
            if (bus.run) begin
              phase_d = PHASE_P0;
            end else begin
              state_d = ST_IDLE;
              phase_d = '0;
            end
          end else begin
            phase_d = phase_q << 1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // A fresh rising edge on the channel being taken re-arms it: set overrides clear.
  always_comb begin
    clr_vec = '0;
    if (take) clr_vec[sel_id] = 1'b1;
    irq_prev_d = bus.irq;
    pending_d  = (pending_q & ~clr_vec) | (bus.irq & ~irq_prev_q);
    ie_d       = take ? 1'b0 : (bus.ie_set ? 1'b1 : ie_q);
    irq_take_d = take;
    taken_id_d = take ? sel_id : taken_id_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      pending_q  <= '0;
      irq_prev_q <= '0;
      ie_q       <= 1'b0;
      irq_take_q <= 1'b0;
      taken_id_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_prev_d;
      ie_q       <= ie_d;
      irq_take_q <= irq_take_d;
      taken_id_q <= taken_id_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.last_phase  = last_phase;
  assign bus.stall       = (|phase_q) & ~bus.mem_ready;
  assign bus.irq_pending = pending_q;
  assign bus.irq_valid   = irq_valid;
  assign bus.irq_take    = irq_take_q;
  assign bus.taken_id    = taken_id_q;
  assign bus.ie          = ie_q;
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised instruction-cycle sequencer for the Computer12 processor core: generates the one-hot phase strobes that step the datapath through fetch/decode/execute. It generalises the fixed three-phase counter to PHASES phases and adds memory wait-state stalling, a run/halt control, and a prioritised, maskable, edge-latched interrupt front end for IRQ_COUNT lines. Interrupts are taken only at instruction boundaries. Sits between the top-level processor wrapper and the decoder/datapath control.

## Interface
- PHASES, default 3: number of phases per instruction cycle (>= 2); width of `phase`.
- IRQ_COUNT, default 24: number of interrupt request lines.
- IRQ_ID_W: derived, ceil(log2(IRQ_COUNT)) (5 at default); width of interrupt IDs. Not user-set.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  1 = start/continue instruction cycles; 0 = halt at next instruction boundary.
- mem_ready  in  1  0 = wait state; phase held this cycle.
- irq  in  IRQ_COUNT  level request lines; rising edges latched.
- irq_mask  in  IRQ_COUNT  1 = channel enabled for selection.
- ie_set  in  1  one-cycle pulse: set global interrupt enable.
- phase  out  PHASES  one-hot phase; all-zero = idle.
- last_phase  out  1  phase[PHASES-1] & mem_ready (instruction completes this edge).
- stall  out  1  phase != 0 & !mem_ready.
- irq_pending  out  IRQ_COUNT  latched requests.
- irq_valid  out  1  ie & |(irq_pending & irq_mask).
- irq_take  out  1  one-cycle pulse: interrupt accepted at boundary.
- taken_id  out  IRQ_ID_W  ID of the last taken interrupt; held until next take.
- ie  out  1  global interrupt enable.

## Operation
- Phase FSM: IDLE (phase=0), then P0..P(PHASES-1), one-hot.
  - IDLE: run=1 -> P0 next edge; else stay.
  - Pi (i < PHASES-1): mem_ready=1 -> P(i+1); mem_ready=0 -> hold.
  - P(PHASES-1): mem_ready=0 -> hold; mem_ready=1 & run=1 -> P0; mem_ready=1 & run=0 -> IDLE.
  - run is sampled only in IDLE and at completion of the last phase; dropping run mid-instruction finishes the instruction.
  - mem_ready is ignored in IDLE.
- Edge latch: irq_prev <= irq every cycle. pending[i] is set on an edge where irq[i] & !irq_prev[i]. The mask does not block latching; it only gates selection.
- Selection: the lowest-index channel with pending & mask wins. sel_id is combinational.
- Take: when last_phase=1 and irq_valid=1 on the same edge:
  - irq_take=1 for the following cycle;
  - taken_id <= sel_id;
  - pending[sel_id] cleared;
  - ie <= 0.
  - Sequencing continues per run (P0 or IDLE).
- ie: set by ie_set, cleared by a take. ie_set on the same edge as a take -> ie=0 (take wins).
- Simultaneous new rising edge and take-clear on the same channel -> pending stays 1 (set wins).
- Reset: all outputs/state 0. phase=0, ie=0, pending=0, irq_prev=0, taken_id=0, irq_take=0. An irq line held high through reset release latches as an edge on the first clock.

## Timing
- With run=1 and mem_ready=1 from reset release: first edge -> P0, then one phase per cycle. Instruction period = PHASES cycles; each wait cycle adds 1.
- irq rising edge sampled at edge t -> pending visible after t -> earliest take at the next completing last phase. irq_take is asserted in the cycle after that edge, coincident with phase=P0 of the handler fetch.
- last_phase, stall, irq_valid: combinational from registers and inputs. irq_take, taken_id, phase, ie, pending: registered.
- Asynchronous reset mid-instruction aborts immediately to IDLE. No partial state survives.

## Test plan
- Reset/free-run, PHASES=3: rst low 125 ns then high, run=1, mem_ready=1, 50 ns clock -> phase 000, 001, 010, 100, 001, ... Period 3 cycles; last_phase high every third cycle.
- Wait states: mem_ready=0 for 2 cycles during P1 -> phase holds 010 for 3 cycles total and stall=1 for 2. Instruction takes 5 cycles.
- Halt: drop run during P0 -> completes P1 and P2, then phase=000. Re-assert run -> P0 on the next edge.
- Priority: ie_set, mask=all ones, irq[7] and irq[3] rise on the same cycle -> first boundary irq_take with taken_id=3, ie=0, pending[7] still 1. After ie_set, next boundary -> take with taken_id=7.
- Mask/set-wins: mask[5]=0 with irq[5] edge -> pending[5]=1, irq_valid=0, no take. Unmask -> take id 5. A new irq[5] edge on the take edge -> pending[5] remains 1.
- Reset mid-operation: assert rst during P1 with pending bits set -> phase, pending, ie, irq_take, taken_id all 0 immediately (asynchronous).
